// File: rtl/axi4_dma_pkg.sv
// Shared AXI constants, write-DMA state encoding and size helper
// for the axi4_dma_write_stream engine.
package axi4_dma_pkg;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } dma_wr_state_e;

  function automatic logic [2:0] size_of(input int unsigned data_w);
    return 3'($clog2(data_w / 8));
  endfunction

endpackage

// File: rtl/axi4_dma_write_stream_len_fifo.sv
// dma_len_fifo: first-word fall-through FIFO of 8-bit burst lengths
// linking accepted AW bursts to the W beat counter.
module dma_len_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic [7:0] din,
  input  logic       pop,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic          do_push;
  logic          do_pop;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= inc(wr_ptr);
      if (do_pop)  rd_ptr <= inc(rd_ptr);
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/axi4_dma_write_stream.sv
// Stream-fed multi-burst AXI4 write DMA with outstanding-burst cap.
// Define AXI_DMA_WR_4K_SPLIT_EN to keep bursts inside 4 KB pages.
module axi4_dma_write_stream
  import axi4_dma_pkg::*;
#(
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 512,
  parameter int ID_W            = 1,
  parameter int LEN_W           = 32,
  parameter int MAX_BURST       = 64,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                clk,
  input  logic                reset,
  output logic                io_axi_awvalid,
  input  logic                io_axi_awready,
  output logic [ADDR_W-1:0]   io_axi_awaddr,
  output logic [ID_W-1:0]     io_axi_awid,
  output logic [7:0]          io_axi_awlen,
  output logic [2:0]          io_axi_awsize,
  output logic [1:0]          io_axi_awburst,
  output logic                io_axi_wvalid,
  input  logic                io_axi_wready,
  output logic [DATA_W-1:0]   io_axi_wdata,
  output logic [DATA_W/8-1:0] io_axi_wstrb,
  output logic                io_axi_wlast,
  input  logic                io_axi_bvalid,
  output logic                io_axi_bready,
  input  logic [ID_W-1:0]     io_axi_bid,
  input  logic [1:0]          io_axi_bresp,
  input  logic                io_s_valid,
  output logic                io_s_ready,
  input  logic [DATA_W-1:0]   io_s_data,
  input  logic [ADDR_W-1:0]   io_start_addr,
  input  logic [LEN_W-1:0]    io_len,
  input  logic                io_ap_start,
  output logic                io_ap_ready,
  output logic                io_ap_done,
  output logic                io_ap_idle,
  output logic                io_err
);

  localparam int         SZ     = $clog2(DATA_W / 8);
  localparam logic [2:0] AXSIZE = size_of(DATA_W);
  localparam int         OW     = $clog2(MAX_OUTSTANDING) + 1;

  dma_wr_state_e     state;
  dma_wr_state_e     state_nxt;
  logic [ADDR_W-1:0] addr;
  logic [LEN_W-1:0]  remaining;
  logic [OW-1:0]     outstanding;
  logic [OW-1:0]     out_nxt;
  logic [7:0]        beat_cnt;
  logic              err;
  logic              done;
  logic [8:0]        cap_n;
  logic [8:0]        burst_n;
  logic              run;
  logic              accept;
  logic              aw_hs;
  logic              w_hs;
  logic              b_hs;
  logic              last_aw;
  logic              drain_ok;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_pop;
  logic [7:0]        fifo_head;
  logic              unused_bid;

  assign unused_bid = ^io_axi_bid;

  assign cap_n = (remaining > LEN_W'(MAX_BURST)) ? 9'(MAX_BURST)
                                                 : remaining[8:0];

`ifdef AXI_DMA_WR_4K_SPLIT_EN
  logic [12:0] to_4k_bytes;
  logic [12:0] to_4k_beats;

  assign to_4k_bytes = 13'h1000 - {1'b0, addr[11:0]};
  assign to_4k_beats = to_4k_bytes >> SZ;
  assign burst_n = (to_4k_beats < 13'(cap_n)) ? to_4k_beats[8:0]
                                              : cap_n;
`else
  assign burst_n = cap_n;
`endif

  assign run     = (state == S_RUN);
  assign accept  = io_ap_ready;
  assign aw_hs   = io_axi_awvalid && io_axi_awready;
  assign w_hs    = io_axi_wvalid && io_axi_wready;
  assign b_hs    = io_axi_bvalid && io_axi_bready;
  assign last_aw = (LEN_W'(burst_n) == remaining);

  // AW fields come only from registers, so they hold during a stall
  assign io_axi_awaddr  = run ? addr : '0;
  assign io_axi_awlen   = run ? 8'(burst_n - 9'd1) : '0;
  assign io_axi_awsize  = run ? AXSIZE : '0;
  assign io_axi_awburst = run ? AXI_BURST_INCR : '0;
  assign io_axi_awid    = '0;

  assign io_axi_wvalid = io_s_valid && !fifo_empty;
  assign io_s_ready    = io_axi_wready && !fifo_empty;
  assign io_axi_wdata  = fifo_empty ? '0 : io_s_data;
  assign io_axi_wstrb  = fifo_empty ? '0 : '1;
  assign io_axi_wlast  = !fifo_empty && (beat_cnt == fifo_head);
  assign fifo_pop      = w_hs && io_axi_wlast;

  assign io_ap_done = done;
  assign io_err     = err;

  dma_len_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_len_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (aw_hs),
    .din   (io_axi_awlen),
    .pop   (fifo_pop),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    out_nxt = outstanding;
    if (aw_hs && !b_hs) begin
      out_nxt = outstanding + 1'b1;
    end else if (b_hs && !aw_hs && outstanding != '0) begin
      out_nxt = outstanding - 1'b1;
    end
  end

  // look ahead at the B handshake so done lands one cycle after it
  assign drain_ok = (state == S_DRAIN) && (out_nxt == '0) && fifo_empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (io_ap_start)
                 state_nxt = (io_len == '0) ? S_DRAIN : S_RUN;
      S_RUN:   if (aw_hs && last_aw) state_nxt = S_DRAIN;
      S_DRAIN: if (drain_ok) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    io_ap_idle     = (state == S_IDLE);
    io_ap_ready    = (state == S_IDLE) && io_ap_start;
    io_axi_bready  = (state != S_IDLE);
    io_axi_awvalid = run && (remaining != '0) &&
                     (outstanding < OW'(MAX_OUTSTANDING)) &&
                     !fifo_full;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr        <= '0;
      remaining   <= '0;
      outstanding <= '0;
      beat_cnt    <= '0;
      err         <= 1'b0;
      done        <= 1'b0;
    end else begin
      if (accept) begin
        addr      <= io_start_addr;
        remaining <= io_len;
      end else if (aw_hs) begin
        addr      <= addr + (ADDR_W'(burst_n) << SZ);
        remaining <= remaining - LEN_W'(burst_n);
      end
      outstanding <= out_nxt;
      if (w_hs) beat_cnt <= io_axi_wlast ? 8'd0 : beat_cnt + 8'd1;
      if (accept) begin
        err <= 1'b0;
      end else if (b_hs && io_axi_bresp != AXI_RESP_OKAY) begin
        err <= 1'b1;
      end
      done <= drain_ok;
    end
  end

endmodule

// File: tb/tb_axi4_dma_write_stream.sv
// Directed bench for axi4_dma_write_stream: slave model on AW/W/B,
// stream source with optional stalls, hand-computed expectations.
`timescale 1ns/1ps
module tb_axi4_dma_write_stream;

  logic         clk = 1'b0;
  logic         reset;
  logic         io_axi_awvalid;
  logic         io_axi_awready;
  logic [31:0]  io_axi_awaddr;
  logic [0:0]   io_axi_awid;
  logic [7:0]   io_axi_awlen;
  logic [2:0]   io_axi_awsize;
  logic [1:0]   io_axi_awburst;
  logic         io_axi_wvalid;
  logic         io_axi_wready;
  logic [511:0] io_axi_wdata;
  logic [63:0]  io_axi_wstrb;
  logic         io_axi_wlast;
  logic         io_axi_bvalid;
  logic         io_axi_bready;
  logic [0:0]   io_axi_bid;
  logic [1:0]   io_axi_bresp;
  logic         io_s_valid;
  logic         io_s_ready;
  logic [511:0] io_s_data;
  logic [31:0]  io_start_addr;
  logic [31:0]  io_len;
  logic         io_ap_start;
  logic         io_ap_ready;
  logic         io_ap_done;
  logic         io_ap_idle;
  logic         io_err;

  axi4_dma_write_stream dut (
    .clk            (clk),
    .reset          (reset),
    .io_axi_awvalid (io_axi_awvalid),
    .io_axi_awready (io_axi_awready),
    .io_axi_awaddr  (io_axi_awaddr),
    .io_axi_awid    (io_axi_awid),
    .io_axi_awlen   (io_axi_awlen),
    .io_axi_awsize  (io_axi_awsize),
    .io_axi_awburst (io_axi_awburst),
    .io_axi_wvalid  (io_axi_wvalid),
    .io_axi_wready  (io_axi_wready),
    .io_axi_wdata   (io_axi_wdata),
    .io_axi_wstrb   (io_axi_wstrb),
    .io_axi_wlast   (io_axi_wlast),
    .io_axi_bvalid  (io_axi_bvalid),
    .io_axi_bready  (io_axi_bready),
    .io_axi_bid     (io_axi_bid),
    .io_axi_bresp   (io_axi_bresp),
    .io_s_valid     (io_s_valid),
    .io_s_ready     (io_s_ready),
    .io_s_data      (io_s_data),
    .io_start_addr  (io_start_addr),
    .io_len         (io_len),
    .io_ap_start    (io_ap_start),
    .io_ap_ready    (io_ap_ready),
    .io_ap_done     (io_ap_done),
    .io_ap_idle     (io_ap_idle),
    .io_err         (io_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cyc, done_cyc, first_aw, first_w, last_w, last_b;
  int aw_cnt, w_cnt, w_bad, aw_bad, aw_unstable, cur_beats, vld_seen;
  logic [31:0] aw_addr_q[$];
  logic [7:0]  aw_len_q[$];
  int          beats_q[$];
  int s_idx, s_total, b_pend, b_allow, b_idx, lat;
  bit s_took, b_took, rnd, prev_stall;
  logic [31:0] p_addr;
  logic [7:0]  p_len;
  logic [1:0]  resp_tab[8];

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [511:0] beat_data(input int k);
    logic [511:0] d;
    for (int j = 0; j < 16; j++) d[j*32 +: 32] = {k[15:0], 8'(j), 8'h5A};
    return d;
  endfunction

  task automatic clear_log();
    aw_cnt = 0; w_cnt = 0; w_bad = 0; aw_bad = 0; aw_unstable = 0;
    cur_beats = 0; vld_seen = 0; prev_stall = 0;
    first_aw = -1; first_w = -1; last_w = -1; last_b = -1;
    done_cyc = -1;
    aw_addr_q.delete(); aw_len_q.delete(); beats_q.delete();
    s_idx = 0; s_took = 0; b_took = 0; b_pend = 0; b_idx = 0;
    io_axi_bvalid = 1'b0;
    for (int i = 0; i < 8; i++) resp_tab[i] = 2'b00;
  endtask

  // passive monitor, sampled mid-cycle
  initial forever begin
    @(negedge clk);
    cyc++;
    if (io_ap_ready) acc_cyc = cyc;
    if (io_ap_done) done_cyc = cyc;
    if (io_axi_awvalid || io_axi_wvalid) vld_seen++;
    if (io_axi_awvalid && first_aw < 0) first_aw = cyc;
    if (prev_stall && (!io_axi_awvalid || io_axi_awaddr != p_addr ||
                       io_axi_awlen != p_len)) aw_unstable++;
    prev_stall = io_axi_awvalid && !io_axi_awready;
    p_addr = io_axi_awaddr;
    p_len = io_axi_awlen;
    if (io_axi_awvalid && io_axi_awready) begin
      aw_cnt++;
      aw_addr_q.push_back(io_axi_awaddr);
      aw_len_q.push_back(io_axi_awlen);
      if (io_axi_awsize != 3'd6 || io_axi_awburst != 2'b01 ||
          io_axi_awid != 1'b0) aw_bad++;
    end
    if (io_axi_wvalid && io_axi_wready) begin
      if (io_axi_wdata != beat_data(w_cnt) || io_axi_wstrb != '1) w_bad++;
      if (first_w < 0) first_w = cyc;
      last_w = cyc;
      w_cnt++;
      cur_beats++;
      if (io_axi_wlast) begin
        beats_q.push_back(cur_beats);
        cur_beats = 0;
        b_pend++;
      end
    end
    if (io_s_valid && io_s_ready) s_took = 1;
    if (io_axi_bvalid && io_axi_bready) begin
      b_took = 1;
      last_b = cyc;
    end
  end

  // stream source and AW/W ready generation
  initial begin
    io_s_valid = 1'b0; io_s_data = '0;
    io_axi_wready = 1'b0; io_axi_awready = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (s_took) begin s_idx++; s_took = 0; end
      io_s_valid = (s_idx < s_total) && (!rnd || $urandom_range(0, 3) != 0);
      io_s_data = beat_data(s_idx);
      io_axi_wready = !rnd || $urandom_range(0, 2) != 0;
      io_axi_awready = !rnd || $urandom_range(0, 1) != 0;
    end
  end

  // B responder: one response per completed burst, gated by b_allow
  initial begin
    io_axi_bvalid = 1'b0; io_axi_bresp = 2'b00; io_axi_bid = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (b_took) begin io_axi_bvalid = 1'b0; b_took = 0; end
      if (!io_axi_bvalid && b_pend > 0 && b_allow > 0) begin
        io_axi_bvalid = 1'b1;
        io_axi_bresp = resp_tab[b_idx % 8];
        b_idx++; b_pend--; b_allow--;
      end
    end
  end

  task automatic start_xfer(input logic [31:0] a, input logic [31:0] n);
    @(posedge clk); #2;
    clear_log();
    s_total = int'(n);
    io_start_addr = a; io_len = n; io_ap_start = 1'b1;
    @(negedge clk); #1;
    chk("ap_ready", io_ap_ready, 1);
    @(posedge clk); #2;
    io_ap_start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int l);
    l = -1;
    for (int i = 0; i < budget && l < 0; i++) begin
      @(negedge clk); #1;
      if (io_ap_done) begin
        l = done_cyc - acc_cyc;
        chk("idle_at_done", io_ap_idle, 1);
      end
    end
    chk("done_seen", l >= 0, 1);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog sim time exceeded");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; io_start_addr = '0; io_len = '0; io_ap_start = 1'b0;
    rnd = 0; s_total = 0; b_allow = 1000; acc_cyc = 0;
    clear_log();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_idle", io_ap_idle, 1);
    chk("rst_awvalid", io_axi_awvalid, 0);
    chk("rst_wvalid", io_axi_wvalid, 0);
    chk("rst_bready", io_axi_bready, 0);
    chk("rst_s_ready", io_s_ready, 0);
    chk("rst_done", io_ap_done, 0);
    chk("rst_err", io_err, 0);
    chk("rst_aw_fields", {io_axi_awaddr, io_axi_awlen, io_axi_awsize,
                          io_axi_awburst}, 0);
    chk("rst_w_fields", {|io_axi_wdata, |io_axi_wstrb, io_axi_wlast}, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    // basic 16-beat transfer
    start_xfer(32'h1000, 16);
    wait_done(100, lat);
    chk("basic_lat", lat, 19);
    chk("basic_aw_cnt", aw_cnt, 1);
    chk("basic_awaddr", aw_addr_q[0], 32'h1000);
    chk("basic_awlen", aw_len_q[0], 15);
    chk("basic_aw_fields", aw_bad, 0);
    chk("basic_first_aw", first_aw - acc_cyc, 1);
    chk("basic_beats", w_cnt, 16);
    chk("basic_wlast", beats_q.size() == 1 && beats_q[0] == 16, 1);
    chk("basic_data", w_bad, 0);
    chk("basic_rate", last_w - first_w, 15);
    chk("basic_b_to_done", done_cyc - last_b, 1);
    chk("basic_err", io_err, 0);

    // page-crossing start
    start_xfer(32'h0FC0, 4);
    wait_done(100, lat);
`ifdef AXI_DMA_WR_4K_SPLIT_EN
    chk("4k_aw_cnt", aw_cnt, 2);
    chk("4k_aw0", {aw_addr_q[0], aw_len_q[0]}, {32'h0FC0, 8'd0});
    chk("4k_aw1", {aw_addr_q[1], aw_len_q[1]}, {32'h1000, 8'd2});
`else
    chk("4k_aw_cnt", aw_cnt, 1);
    chk("4k_aw0", {aw_addr_q[0], aw_len_q[0]}, {32'h0FC0, 8'd3});
`endif
    chk("4k_beats", w_cnt, 4);
    chk("4k_data", w_bad, 0);

    // outstanding cap with B withheld
    b_allow = 0;
    start_xfer(32'h10000, 320);
    repeat (300) @(negedge clk);
    #1;
    chk("cap_aw_cnt", aw_cnt, 4);
    chk("cap_w_cnt", w_cnt, 256);
    chk("cap_awvalid", io_axi_awvalid, 0);
    b_allow = 1;
    repeat (10) @(negedge clk);
    #1;
    chk("cap_aw5_cnt", aw_cnt, 5);
    chk("cap_aw5_addr", aw_addr_q[4], 32'h14000);
    b_allow = 1000;
    wait_done(400, lat);
    chk("cap_beats", w_cnt, 320);
    chk("cap_bursts", beats_q.size(), 5);
    chk("cap_data", w_bad, 0);

    // zero length
    start_xfer(32'h5000, 0);
    wait_done(20, lat);
    chk("zl_lat", lat, 2);
    chk("zl_no_valid", vld_seen, 0);

    // error on second of three responses
    start_xfer(32'h20000, 192);
    resp_tab[1] = 2'b10;
    wait_done(400, lat);
    chk("err_bursts", beats_q.size(), 3);
    chk("err_at_done", io_err, 1);
    repeat (3) @(negedge clk);
    #1;
    chk("err_held", io_err, 1);
    start_xfer(32'h30000, 1);
    @(negedge clk); #1;
    chk("err_cleared", io_err, 0);
    wait_done(50, lat);
    chk("err_clean_run", io_err, 0);

    // random backpressure on stream, W and AW
    rnd = 1;
    start_xfer(32'h40000, 100);
    wait_done(2000, lat);
    rnd = 0;
    chk("bp_beats", w_cnt, 100);
    chk("bp_data", w_bad, 0);
    chk("bp_aw_cnt", aw_cnt, 2);
    chk("bp_aw0", {aw_addr_q[0], aw_len_q[0]}, {32'h40000, 8'd63});
    chk("bp_aw1", {aw_addr_q[1], aw_len_q[1]}, {32'h41000, 8'd35});
    chk("bp_bursts", beats_q.size() == 2 && beats_q[0] == 64 &&
                     beats_q[1] == 36, 1);
    chk("bp_aw_stable", aw_unstable, 0);

    // reset in the middle of a burst
    b_allow = 0;
    start_xfer(32'h50000, 200);
    repeat (20) @(negedge clk);
    #1;
    chk("mid_busy", io_ap_idle, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk("mid_rst_awvalid", io_axi_awvalid, 0);
    chk("mid_rst_wvalid", io_axi_wvalid, 0);
    chk("mid_rst_s_ready", io_s_ready, 0);
    chk("mid_rst_bready", io_axi_bready, 0);
    chk("mid_rst_idle", io_ap_idle, 1);
    @(posedge clk); #1;
    reset = 1'b0;
    b_allow = 1000;
    start_xfer(32'h60000, 2);
    wait_done(50, lat);
    chk("post_rst_lat", lat, 5);
    chk("post_rst_beats", w_cnt, 2);
    chk("post_rst_data", w_bad, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
